// File: rtl/uart_tx_ser.sv
// Purpose: serial UART transmitter, one byte per txdata_rdy strobe out as an 8N1 frame (8E1/8O1 with UART_PARITY_EN defined).
// Latency: start bit on uart_tx and txBusy=1 the cycle after the accept edge; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: txBusy is high for the whole frame; strobes seen while busy are dropped.
module uart_tx_ser #(
  parameter int CLKS_PER_BIT = 1250,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       txdata_rdy,
  output logic       txBusy,
  output logic       uart_tx
);

  // The baud counter must be able to reach CLKS_PER_BIT-1 and a bit needs
  // at least two clocks.
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  // Reject a bit period shorter than two clocks at elaboration time.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_ser: CLKS_PER_BIT must be >= 2");
  end

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
  // Parity sense has no meaning in a plain 8N1 build.
  localparam bit unused_parity_odd = PARITY_ODD;
`endif

  state_t          state_q, state_n;
  logic [CW-1:0]   baud_q, baud_n;
  logic [2:0]      bit_q, bit_n;
  logic [7:0]      shreg_q, shreg_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            baud_last;
`ifdef UART_PARITY_EN
  logic            par_q, par_n;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  // State and output registers; reset truncates any frame and idles the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
`ifdef UART_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  // Next-state, baud/bit counting and next line value; outputs are the registers.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shreg_n = shreg_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
`ifdef UART_PARITY_EN
    par_n   = par_q;
`endif

    if (state_q == ST_IDLE) begin
      // Counters parked at zero so every frame starts with a full start bit.
      baud_n = '0;
      bit_n  = '0;
      tx_n   = 1'b1;
      busy_n = 1'b0;
      if (txdata_rdy) begin
        shreg_n = txdata;
        tx_n    = 1'b0;
        busy_n  = 1'b1;
        state_n = ST_START;
`ifdef UART_PARITY_EN
        par_n   = (^txdata) ^ PARITY_ODD;
`endif
      end
    end else if (!baud_last) begin
      baud_n = baud_q + 1'b1;
    end else begin
      baud_n = '0;
      case (state_q)
        ST_START: begin
          state_n = ST_DATA;
          bit_n   = '0;
          tx_n    = shreg_q[0];
        end
        ST_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = par_q;
`else
            state_n = ST_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            // Shift right so the next data bit is always at index 1 -> 0.
            bit_n   = bit_q + 3'd1;
            shreg_n = {1'b0, shreg_q[7:1]};
            tx_n    = shreg_q[1];
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end
`endif
        ST_STOP: begin
          // Busy drops on the same edge that returns to idle.
          state_n = ST_IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  assign txBusy  = busy_q;
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: two instances (4 and 2 clocks per bit) watched by one frame monitor.
// Stimulus pushes expected byte and start cycle; the monitor pops and checks every line sample.
// Reset behaviour is checked directly between clock edges.
module tb_uart_tx_ser;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL4 = NB * 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] txdata = 8'h00;
  logic       rdy4 = 1'b0, rdy2 = 1'b0;
  logic       busy4, tx4, busy2, tx2;

  always #5 clk = ~clk;

  uart_tx_ser #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut4 (
    .clk(clk), .reset(reset), .txdata(txdata), .txdata_rdy(rdy4),
    .txBusy(busy4), .uart_tx(tx4));

  uart_tx_ser #(.CLKS_PER_BIT(2), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .reset(reset), .txdata(txdata), .txdata_rdy(rdy2),
    .txBusy(busy2), .uart_tx(tx2));

  typedef struct {
    logic [7:0] b;
    int         start;
    bit         on2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: follows whichever DUT sel2 selects.
  bit          sel2 = 1'b0;
  logic        mtx, mbusy;
  int          cpb;
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [10:0] m_bits = '0;
  exp_t        m_e;

  assign mtx   = sel2 ? tx2 : tx4;
  assign mbusy = sel2 ? busy2 : busy4;
  assign cpb   = sel2 ? 2 : 4;

  always @(negedge clk) begin
    if (reset) begin
      m_act = 1'b0;
    end else begin
      if (!m_act && mtx === 1'b0) begin
        chk("frame_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          m_e = q.pop_front();
          chk("start_cycle", cyc, m_e.start);
          chk("frame_dut", 32'(sel2), 32'(m_e.on2));
`ifdef UART_PARITY_EN
          m_bits = {1'b1, (^m_e.b) ^ m_e.on2, m_e.b, 1'b0};
`else
          m_bits = {1'b0, 1'b1, m_e.b, 1'b0};
`endif
          m_act = 1'b1;
          m_t   = 0;
        end
      end
      if (m_act) begin
        if (m_t < NB * cpb) begin
          chk($sformatf("line_bit%0d", m_t / cpb), 32'(mtx), 32'(m_bits[m_t / cpb]));
          chk("busy_in_frame", 32'(mbusy), 32'd1);
        end else begin
          chk("idle_line_after_stop", 32'(mtx), 32'd1);
          chk("busy_after_stop", 32'(mbusy), 32'd0);
          m_act = 1'b0;
        end
        m_t++;
      end
    end
  end

  // Drive a one-cycle strobe from a negedge; the accept edge is the next posedge.
  task automatic strobe(input logic [7:0] d, input bit on2);
    exp_t e;
    e.b = d; e.start = cyc + 1; e.on2 = on2;
    q.push_back(e);
    txdata = d;
    if (on2) rdy2 = 1'b1; else rdy4 = 1'b1;
    @(negedge clk);
    rdy4 = 1'b0;
    rdy2 = 1'b0;
    txdata = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b;
    exp_t e;
    // Power-on reset.
    #2 reset = 1'b1;
    #10;
    chk("rst_tx4", 32'(tx4), 32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    idle(3);

    // Single frame 0x41: 0,1,0,0,0,0,0,1,0,1.
    strobe(8'h41, 1'b0);
    idle(FL4 + 5);

    // Back-to-back: second strobe in the first idle cycle starts one cycle after stop.
    strobe(8'h0d, 1'b0);
    idle(FL4);
    strobe(8'h0a, 1'b0);
    idle(FL4 + 5);

    // Strobe every cycle for 50 cycles: accepts at the first edge and the first idle cycle.
    b = cyc;
    e.b = 8'h33; e.on2 = 1'b0;
    e.start = b + 1;       q.push_back(e);
    e.start = b + FL4 + 2; q.push_back(e);
    for (int k = 0; k < 50; k++) begin
      txdata = 8'h33;
      rdy4 = 1'b1;
      @(negedge clk);
    end
    rdy4 = 1'b0;
    idle(FL4 + 5);

    // Reset mid-frame while data bit 1 (a 0 for 0x55) is on the line.
    strobe(8'h55, 1'b0);
    idle(9);
    chk("line_low_before_reset", 32'(tx4), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx4", 32'(tx4), 32'd1);
    chk("midrst_busy4", 32'(busy4), 32'd0);
    idle(2);
    #2 reset = 1'b0;
    idle(2);
    strobe(8'h0d, 1'b0);
    idle(FL4 + 5);

`ifdef UART_PARITY_EN
    // Even parity on the 4-clock instance: 0x07 -> parity bit 1.
    strobe(8'h07, 1'b0);
    idle(FL4 + 5);
`endif

    // Two clocks per bit: 0xff -> 0 then all ones, each held 2 cycles.
    sel2 = 1'b1;
    idle(2);
    strobe(8'hff, 1'b1);
    idle(NB * 2 + 5);
`ifdef UART_PARITY_EN
    // Odd parity on the 2-clock instance: 0x07 -> parity bit 0.
    strobe(8'h07, 1'b1);
    idle(NB * 2 + 5);
`endif

    // Drain with a bound.
    for (int k = 0; k < 200 && (q.size() != 0 || m_act); k++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("monitor_idle", 32'(m_act), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
